// File: rtl/pll_ctrl_pkg.sv
// Shared state encoding and default sizing for the PLL controller and its divider.
package pll_ctrl_pkg;

  localparam int PLL_DIV_W       = 4;
  localparam int PLL_LOCK_CYCLES = 8;
  localparam int PLL_DEF_DIV     = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RAMP   = 2'd1,
    ST_LOCKED = 2'd2,
    ST_RECONF = 2'd3
  } pll_state_e;

endpackage

// File: rtl/pll_ctrl_clk_div_gen.sv
// Half-period counter and toggle: clk_div flips every `half` CLK cycles while run is high.
module clk_div_gen #(
  parameter int DIV_W = 4
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             i_run,
  input  logic [DIV_W-1:0] i_half,
  output logic             o_clk_div,
  output logic             o_div_tick
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_clk_div;
  logic             r_div_tick;

  // Dropping run parks the divider at its start phase so the next run begins cleanly.
  always_ff @(posedge CLK) begin
    if (reset || !i_run) begin
      r_cnt      <= DIV_W'(1);
      r_clk_div  <= 1'b0;
      r_div_tick <= 1'b0;
    end else if (r_cnt == i_half) begin
      r_cnt      <= DIV_W'(1);
      r_clk_div  <= ~r_clk_div;
      r_div_tick <= ~r_clk_div;
    end else begin
      r_cnt      <= r_cnt + 1'b1;
      r_div_tick <= 1'b0;
    end
  end

  assign o_clk_div  = r_clk_div;
  assign o_div_tick = r_div_tick;

endmodule

// File: rtl/pll_ctrl.sv
// PLL controller: run/lock FSM, lock counter and rate_req/rate_ack handshake around clk_div_gen.
// Handshake: rate_req is held by the requester until rate_ack; rate_ack pulses for exactly one
// cycle on acceptance and never on two consecutive cycles.
module pll_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int DIV_W       = PLL_DIV_W,
  parameter int LOCK_CYCLES = PLL_LOCK_CYCLES,
  parameter int DEF_DIV     = PLL_DEF_DIV
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_rate_req,
  input  logic [DIV_W-1:0] i_rate_div,
  output logic             o_rate_ack,
  output logic             o_pll_run,
  output logic             o_lock,
  output logic             o_clk_div,
  output logic             o_div_tick,
  output pll_state_e       o_state
);

  localparam int LC_W = $clog2(LOCK_CYCLES + 1);

  pll_state_e       r_state;
  pll_state_e       w_next;
  logic [DIV_W-1:0] r_half;
  logic [DIV_W-1:0] w_half_new;
  logic [LC_W-1:0]  r_lock_cnt;
  logic             r_rate_ack;
  logic             r_pll_run;
  logic             r_lock;
  logic             w_accept;
  logic             w_lock_last;
  logic             w_running_now;
  logic             w_running_next;
  logic             w_run;
  logic             w_clk_div;
  logic             w_div_tick;

  assign w_half_new     = (i_rate_div == '0) ? DIV_W'(1) : i_rate_div;
  assign w_lock_last    = (r_lock_cnt == LC_W'(LOCK_CYCLES - 1));
  assign w_running_now  = (r_state == ST_RAMP) || (r_state == ST_LOCKED);
  assign w_running_next = (w_next == ST_RAMP) || (w_next == ST_LOCKED);
  // The divider only steps while staying in RAMP/LOCKED, so entering RAMP starts at cnt=1.
  assign w_run          = w_running_now && w_running_next;

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A request in IDLE only reloads half; ramping waits one more cycle.
        if (i_rate_req && !r_rate_ack) begin
          w_accept = 1'b1;
        end else if (i_en) begin
          w_next = ST_RAMP;
        end
      end
      ST_RAMP: begin
        if (!i_en) begin
          w_next = ST_IDLE;
        end else if (w_div_tick && w_lock_last) begin
          w_next = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (!i_en) begin
          w_next = ST_IDLE;
        end else if (i_rate_req && !r_rate_ack) begin
          w_accept = 1'b1;
          w_next   = ST_RECONF;
        end
      end
      ST_RECONF: begin
        w_next = i_en ? ST_RAMP : ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_half     <= DIV_W'(DEF_DIV);
      r_lock_cnt <= '0;
      r_rate_ack <= 1'b0;
      r_pll_run  <= 1'b0;
      r_lock     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_rate_ack <= w_accept;
      r_pll_run  <= (w_next != ST_IDLE);
      r_lock     <= (w_next == ST_LOCKED);
      if (w_accept) begin
        r_half <= w_half_new;
      end
      if (!w_running_next) begin
        r_lock_cnt <= '0;
      end else if ((r_state == ST_RAMP) && w_div_tick && (r_lock_cnt != LC_W'(LOCK_CYCLES))) begin
        r_lock_cnt <= r_lock_cnt + 1'b1;
      end
    end
  end

  clk_div_gen #(
    .DIV_W (DIV_W)
  ) u_clk_div_gen (
    .CLK        (CLK),
    .reset      (reset),
    .i_run      (w_run),
    .i_half     (r_half),
    .o_clk_div  (w_clk_div),
    .o_div_tick (w_div_tick)
  );

  assign o_rate_ack = r_rate_ack;
  assign o_pll_run  = r_pll_run;
  assign o_lock     = r_lock;
  assign o_clk_div  = w_clk_div;
  assign o_div_tick = w_div_tick;
  assign o_state    = r_state;

endmodule
